// File: rtl/clock_defs.sv
// Shared BCD time constants and digit-pair validity check
// for the clock, display and alarm logic.
package clock_defs;

  localparam int BCD_W = 8;

  localparam logic [BCD_W-1:0] SEC_MAX = 8'h59;
  localparam logic [BCD_W-1:0] MIN_MAX = 8'h59;
  localparam logic [BCD_W-1:0] HR_MAX  = 8'h23;
  localparam logic [BCD_W-1:0] HR_NOON = 8'h12;

  // Both nibbles are decimal digits and the pair does not exceed max.
  function automatic logic bcd_ok(
    input logic [BCD_W-1:0] v,
    input logic [BCD_W-1:0] max
  );
    return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd9) && (v <= max);
  endfunction

endpackage

// File: rtl/bcd_pair_counter.sv
// Two-digit BCD up/down counter wrapping between 00 and MAX,
// with parallel load and same-cycle carry/borrow outputs.
module bcd_pair_counter
  import clock_defs::*;
#(
  parameter logic [BCD_W-1:0] MAX = SEC_MAX
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  input  logic             ld,
  input  logic [BCD_W-1:0] ld_val,
  output logic [BCD_W-1:0] val,
  output logic             carry,
  output logic             borrow
);

  logic [BCD_W-1:0] up_val;
  logic [BCD_W-1:0] dn_val;
  logic [BCD_W-1:0] nxt;

  assign carry  = inc && (val == MAX);
  assign borrow = dec && (val == '0);

  always_comb begin
    up_val = val + 8'd1;
    if (val[3:0] == 4'd9)
      up_val = {val[7:4] + 4'd1, 4'd0};
    dn_val = val - 8'd1;
    if (val[3:0] == 4'd0)
      dn_val = {val[7:4] - 4'd1, 4'd9};
  end

  always_comb begin
    nxt = val;
    if (ld)
      nxt = ld_val;
    else if (inc)
      nxt = carry ? '0 : up_val;
    else if (dec)
      nxt = borrow ? MAX : dn_val;
  end

  always_ff @(posedge clk) begin
    if (rst)
      val <= '0;
    else
      val <= nxt;
  end

endmodule

// File: rtl/bcd_time_counter.sv
// HH:MM:SS BCD time-of-day counter with seconds prescaler,
// up/down modes, validated load and 12h/24h hour display.
module bcd_time_counter
  import clock_defs::*;
#(
  parameter int CLK_PER_SEC = 50_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic             mode_12h,
  input  logic             load,
  input  logic [BCD_W-1:0] load_hh,
  input  logic [BCD_W-1:0] load_mm,
  input  logic [BCD_W-1:0] load_ss,
  output logic [BCD_W-1:0] hh,
  output logic [BCD_W-1:0] mm,
  output logic [BCD_W-1:0] ss,
  output logic             pm,
  output logic             sec_tick,
  output logic             wrap,
  output logic             load_err
);

  localparam int PW = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(CLK_PER_SEC - 1);

  logic [PW-1:0]    pre;
  logic [BCD_W-1:0] hr, mn, sc;
  logic             ld_ok, tick, up, dn;
  logic             at_zero, at_one, wrap_nxt;
  logic             sc_c, sc_b, mn_c, mn_b, hr_c, hr_b;

  assign ld_ok = load
               && bcd_ok(load_hh, HR_MAX)
               && bcd_ok(load_mm, MIN_MAX)
               && bcd_ok(load_ss, SEC_MAX);

  // A load request in the tick cycle swallows that tick.
  assign tick = en && (pre == PRE_LAST) && !load;

  assign at_zero = (hr == '0) && (mn == '0) && (sc == '0);
  assign at_one  = (hr == '0) && (mn == '0) && (sc == 8'h01);

  assign up = tick && !dir;
  assign dn = tick && dir && !at_zero;

  assign wrap_nxt = (up && hr_c) || (dn && at_one);

  bcd_pair_counter #(.MAX(SEC_MAX)) u_sec (
    .clk    (clk),
    .rst    (rst),
    .inc    (up),
    .dec    (dn),
    .ld     (ld_ok),
    .ld_val (load_ss),
    .val    (sc),
    .carry  (sc_c),
    .borrow (sc_b)
  );

  bcd_pair_counter #(.MAX(MIN_MAX)) u_min (
    .clk    (clk),
    .rst    (rst),
    .inc    (sc_c),
    .dec    (sc_b),
    .ld     (ld_ok),
    .ld_val (load_mm),
    .val    (mn),
    .carry  (mn_c),
    .borrow (mn_b)
  );

  bcd_pair_counter #(.MAX(HR_MAX)) u_hr (
    .clk    (clk),
    .rst    (rst),
    .inc    (mn_c),
    .dec    (mn_b),
    .ld     (ld_ok),
    .ld_val (load_hh),
    .val    (hr),
    .carry  (hr_c),
    .borrow (hr_b)
  );

  always_ff @(posedge clk) begin
    if (rst)
      pre <= '0;
    else if (load) begin
      if (ld_ok)
        pre <= '0;
    end else if (en)
      pre <= (pre == PRE_LAST) ? '0 : pre + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sec_tick <= 1'b0;
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      sec_tick <= tick;
      wrap     <= wrap_nxt;
      load_err <= load && !ld_ok;
    end
  end

  logic [4:0] hb, h12, h12m10;

  always_comb begin
    hb     = 5'(hr[7:4]) * 5'd10 + 5'(hr[3:0]);
    h12    = hb;
    if (hb == 5'd0)
      h12 = 5'd12;
    else if (hb > 5'd12)
      h12 = hb - 5'd12;
    h12m10 = h12 - 5'd10;
    hh     = hr;
    if (mode_12h)
      hh = (h12 >= 5'd10) ? {4'd1, h12m10[3:0]}
                          : {4'd0, h12[3:0]};
  end

  assign pm = mode_12h && (hr >= HR_NOON);
  assign mm = mn;
  assign ss = sc;

  logic unused_b;
  assign unused_b = hr_b;

endmodule
